// File: rtl/program_load_ctrl.sv
// Program loader and front-end gate: packs host bytes into instruction words,
// writes them to program memory, then releases and halts the core.
module program_load_ctrl #(
  parameter int              ADDR_W      = 12,
  parameter int              DATA_W      = 32,
  parameter logic [6:0]      HALT_OPCODE = 7'b1111111,
  parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_count,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  input  logic              run_start,
  input  logic              halt_clear,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] instr_in,
  output logic [DATA_W-1:0] instr_out,
  output logic              cpu_stall,
  output logic              load_done,
  output logic              halted
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_HALT = 2'd3;

  localparam logic [ADDR_W-1:0] WORD_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        state;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] word_cnt;
  logic [ADDR_W-1:0] count_q;
  logic [23:0]       shift_q;
  logic              is_halt_op;

  assign is_halt_op = (instr_in[6:0] == HALT_OPCODE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      byte_idx  <= 2'd0;
      word_cnt  <= '0;
      count_q   <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      load_done <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      load_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_start) begin
            state    <= S_LOAD;
            count_q  <= load_count;
            word_cnt <= '0;
            byte_idx <= 2'd0;
          end else if (run_start) begin
            state <= S_RUN;
          end
        end
        S_LOAD: begin
          if (load_valid) begin
            byte_idx <= byte_idx + 2'd1;
            // Fourth byte goes straight into the write word; lanes 0..2 come from shift_q.
            if (byte_idx == 2'd3) begin
              mem_we    <= 1'b1;
              mem_waddr <= word_cnt;
              mem_wdata <= {load_data, shift_q};
              word_cnt  <= word_cnt + WORD_ONE;
              if (word_cnt == count_q) begin
                state     <= S_IDLE;
                load_done <= 1'b1;
              end
            end
          end
        end
        S_RUN: begin
          if (is_halt_op) state <= S_HALT;
        end
        default: begin
          if (halt_clear) state <= S_IDLE;
        end
      endcase
    end
  end

  // Byte lanes are pure data, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == S_LOAD && load_valid && byte_idx != 2'd3)
      shift_q[{byte_idx, 3'b000} +: 8] <= load_data;
  end

  assign load_ready = (state == S_LOAD);
  assign cpu_stall  = (state != S_RUN);
  assign halted     = (state == S_HALT);
  assign instr_out  = (state == S_RUN && !is_halt_op) ? instr_in : NOP_INSTR;

endmodule
